cozy_mem_arbiter: RTL and testbench

//  Two-master arbiter sitting directly upstream of the byte-laned 16-bit block RAM.

---
 rtl/cozy_mem_arbiter_if.sv | 46 ++++
 rtl/cozy_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_cozy_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cozy_mem_arbiter_if.sv
// Bundle of both requester ports and the RAM port of the two-master arbiter.
// The arbiter connects through the slave modport. The master modport is the
// environment side: both requesters plus the RAM read-data return.
interface cozy_mem_arbiter_if;
  // CPU requester (m0)
  logic        m0_req;
  logic [15:0] m0_addr;
  logic [15:0] m0_din;
  logic [1:0]  m0_bwe;
  logic        m0_ack;
  logic        m0_rvalid;
  logic [15:0] m0_rdata;

  // Video/DMA requester (m1)
  logic        m1_req;
  logic [15:0] m1_addr;
  logic [15:0] m1_din;
  logic [1:0]  m1_bwe;
  logic        m1_ack;
  logic        m1_rvalid;
  logic [15:0] m1_rdata;

  // Single RAM port
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_bwe;
  logic [15:0] mem_dout;

  modport slave (
    input  m0_req, m0_addr, m0_din, m0_bwe,
    output m0_ack, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_din, m1_bwe,
    output m1_ack, m1_rvalid, m1_rdata,
    output mem_addr, mem_din, mem_bwe,
    input  mem_dout
  );

  modport master (
    output m0_req, m0_addr, m0_din, m0_bwe,
    input  m0_ack, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_din, m1_bwe,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  mem_addr, mem_din, mem_bwe,
    output mem_dout
  );
endinterface

// File: rtl/cozy_mem_arbiter.sv
// Two-master arbiter in front of the byte-laned 16-bit block RAM.
// m1 (video/DMA) wins contention by default so scanout stays real-time; a
// saturating wait counter forces a win for m0 (CPU) after MAX_WAIT lost
// contended cycles. Read data has one cycle of latency and is steered back to
// whichever master issued the read, tracked by the rd_owner register.
module cozy_mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cozy_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // rd_owner encoding is one-hot per master so that each rvalid is a plain
  // register bit rather than a decode of the state.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  owner_e     rd_owner_reg;
  owner_e     rd_owner_next;
  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;

  // Per-master views of the interface, index 0 = m0, index 1 = m1
  logic [1:0]       req;
  logic [1:0][15:0] addr;
  logic [1:0][15:0] din;
  logic [1:0][1:0]  bwe_raw;
  logic [1:0][1:0]  bwe_eff;
  logic [1:0]       is_read;
  logic [1:0]       grant;
  logic [1:0]       rvalid;
  logic [1:0][15:0] rdata;

  assign req[0]     = bus.m0_req;
  assign req[1]     = bus.m1_req;
  assign addr[0]    = bus.m0_addr;
  assign addr[1]    = bus.m1_addr;
  assign din[0]     = bus.m0_din;
  assign din[1]     = bus.m1_din;
  assign bwe_raw[0] = bus.m0_bwe;
  assign bwe_raw[1] = bus.m1_bwe;

  // Only 01 (byte) and 11 (word) are writes; 10 degrades to a read so the
  // RAM never sees a high-byte-only strobe.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bwe
      assign bwe_eff[gi] = ((bwe_raw[gi] == 2'b01) || (bwe_raw[gi] == 2'b11))
                           ? bwe_raw[gi] : 2'b00;
      assign is_read[gi] = (bwe_eff[gi] == 2'b00);
    end
  endgenerate

  // Grant selection: m1 favoured unless m0 has waited MAX_WAIT contended
  // cycles. Held at no-grant while reset is asserted so nothing reaches RAM.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (req[0] && req[1]) begin
        grant = (wait_cnt_reg == WAIT_LIMIT) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  assign bus.m0_ack = grant[0];
  assign bus.m1_ack = grant[1];

  // RAM port mux; with no grant, present a harmless read at m0's address.
  always_comb begin
    bus.mem_addr = addr[0];
    bus.mem_din  = 16'h0000;
    bus.mem_bwe  = 2'b00;
    if (grant[0]) begin
      bus.mem_addr = addr[0];
      bus.mem_din  = din[0];
      bus.mem_bwe  = bwe_eff[0];
    end else if (grant[1]) begin
      bus.mem_addr = addr[1];
      bus.mem_din  = din[1];
      bus.mem_bwe  = bwe_eff[1];
    end
  end

  // Next-state for the starvation counter and the read-return owner.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    rd_owner_next = OWN_NONE;

    if (!req[0] || grant[0]) begin
      wait_cnt_next = 4'd0;
    end else if (req[1] && grant[1] && (wait_cnt_reg < WAIT_LIMIT)) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end

    if (grant[0] && is_read[0]) begin
      rd_owner_next = OWN_M0;
    end else if (grant[1] && is_read[1]) begin
      rd_owner_next = OWN_M1;
    end
  end

  // State register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 4'd0;
      rd_owner_reg <= OWN_NONE;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // Read return: RAM data passes through unmodified to the owner only.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      assign rvalid[gi] = rd_owner_reg[gi];
      assign rdata[gi]  = rvalid[gi] ? bus.mem_dout : 16'h0000;
    end
  endgenerate

  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];

endmodule

// File: tb/tb_cozy_mem_arbiter.sv
// Directed bench for cozy_mem_arbiter with a behavioural byte-laned RAM and a
// scoreboard of expected read returns checked by a negedge monitor.
module tb_cozy_mem_arbiter;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   cyc;

  cozy_mem_arbiter_if bus();

  cozy_mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Behavioural RAM: word index addr[10:1]; byte write lands in the lane
  // chosen by addr[0]; reads at odd addresses return {8'h00, high byte}.
  logic [15:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_bwe == 2'b11) begin
      ram[bus.mem_addr[10:1]] <= bus.mem_din;
    end else if (bus.mem_bwe == 2'b01) begin
      if (bus.mem_addr[0]) ram[bus.mem_addr[10:1]][15:8] <= bus.mem_din[7:0];
      else                 ram[bus.mem_addr[10:1]][7:0]  <= bus.mem_din[7:0];
    end
    bus.mem_dout <= bus.mem_addr[0] ? {8'h00, ram[bus.mem_addr[10:1]][15:8]}
                                    : ram[bus.mem_addr[10:1]];
  end

  typedef struct {
    logic        m;
    logic [15:0] data;
    int          at_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected read return one cycle after the issuing cycle.
  task automatic push(input logic m, input logic [15:0] data);
    exp_t e;
    e.m = m;
    e.data = data;
    e.at_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input int m, input logic req, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] w);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_addr = a; bus.m0_din = d; bus.m0_bwe = w;
    end else begin
      bus.m1_req = req; bus.m1_addr = a; bus.m1_din = d; bus.m1_bwe = w;
    end
  endtask

  task automatic check_acks(input string tag, input logic a0, input logic a1);
    check({tag, "_m0_ack"}, bus.m0_ack, a0);
    check({tag, "_m1_ack"}, bus.m1_ack, a1);
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expectation in
  // master, data and cycle; idle rdata must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (bus.m0_rvalid || bus.m1_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
      end else begin
        e = sb.pop_front();
        $display("read return: master m%0d data %h cycle %0d", e.m, e.data, cyc);
        check("rvalid_master", {bus.m1_rvalid, bus.m0_rvalid}, e.m ? 2'b10 : 2'b01);
        check("rdata", e.m ? bus.m1_rdata : bus.m0_rdata, e.data);
        check("rvalid_cycle", cyc, e.at_cyc);
      end
    end
    if (!bus.m0_rvalid) check("m0_rdata_idle", bus.m0_rdata, 16'h0000);
    if (!bus.m1_rvalid) check("m1_rdata_idle", bus.m1_rdata, 16'h0000);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_m0;
    pass_cnt = 0;
    total_cnt = 0;
    cyc = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    ram[0]     = 16'h1111;  // 0x0000
    ram[1]     = 16'h2222;  // 0x0002
    ram[2]     = 16'h3333;  // 0x0004
    ram[16]    = 16'h1234;  // 0x0020/0x0021
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (2) @(posedge clk);

    // 1: reset holds off both masters even when both request
    @(negedge clk);
    drive(0, 1'b1, 16'h0200, 16'h0000, 2'b00);
    drive(1, 1'b1, 16'h0200, 16'hAAAA, 2'b11);
    #1;
    check_acks("rst", 1'b0, 1'b0);
    check("rst_mem_bwe", bus.mem_bwe, 2'b00);
    check("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("txn: release reset, contention -> m1 write AAAA @0200");
    check_acks("rel", 1'b0, 1'b1);
    check("rel_mem_bwe", bus.mem_bwe, 2'b11);
    check("rel_mem_addr", bus.mem_addr, 16'h0200);
    check("rel_mem_din", bus.mem_din, 16'hAAAA);
    @(negedge clk);
    drive(1, 1'b0, 16'h0000, 16'h0000, 2'b00);
    #1;
    $display("txn: m0 read @0200");
    check_acks("rel_rd", 1'b1, 1'b0);
    check("rel_rd_bwe", bus.mem_bwe, 2'b00);
    push(1'b0, 16'hAAAA);

    // 2: m0 alone, word write then read back
    @(negedge clk);
    drive(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
    #1;
    $display("txn: m0 write BEEF @0010");
    check_acks("m0wr", 1'b1, 1'b0);
    check("m0wr_mem_bwe", bus.mem_bwe, 2'b11);
    check("m0wr_mem_din", bus.mem_din, 16'hBEEF);
    check("m0wr_mem_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    drive(0, 1'b1, 16'h0010, 16'h0000, 2'b00);
    #1;
    $display("txn: m0 read @0010");
    check_acks("m0rd", 1'b1, 1'b0);
    check("m0rd_mem_bwe", bus.mem_bwe, 2'b00);
    push(1'b0, 16'hBEEF);
    @(negedge clk);
    drive(0, 1'b0, 16'h0030, 16'h0000, 2'b00);
    #1;
    $display("txn: idle");
    check_acks("idle", 1'b0, 1'b0);
    check("idle_mem_bwe", bus.mem_bwe, 2'b00);
    check("idle_mem_din", bus.mem_din, 16'h0000);
    check("idle_mem_addr", bus.mem_addr, 16'h0030);

    // 3: continuous contention, m0 forced a win every fifth cycle
    @(negedge clk);
    drive(0, 1'b1, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b1, 16'h0002, 16'h0000, 2'b00);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_m0 = ((i % 5) == 4);
      $display("txn: contention step %0d expect m%0d", i, exp_m0 ? 0 : 1);
      check_acks($sformatf("cont%0d", i), exp_m0, !exp_m0);
      if (exp_m0) push(1'b0, 16'h1111);
      else        push(1'b1, 16'h2222);
    end

    // 4: m1 byte write at odd address, m0 reads it back unaligned
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b1, 16'h0021, 16'hFF5A, 2'b01);
    #1;
    $display("txn: m1 byte write 5A @0021");
    check_acks("bw", 1'b0, 1'b1);
    check("bw_mem_bwe", bus.mem_bwe, 2'b01);
    @(negedge clk);
    drive(1, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(0, 1'b1, 16'h0021, 16'h0000, 2'b00);
    #1;
    $display("txn: m0 read @0021");
    check_acks("bwrd", 1'b1, 1'b0);
    push(1'b0, 16'h005A);
    @(negedge clk);
    drive(0, 1'b1, 16'h0000, 16'hDEAD, 2'b10);
    #1;
    $display("txn: m0 bwe=10 @0000 treated as read");
    check_acks("bwe10", 1'b1, 1'b0);
    check("bwe10_mem_bwe", bus.mem_bwe, 2'b00);
    push(1'b0, 16'h1111);

    // 5: alternating back-to-back reads
    @(negedge clk);
    drive(0, 1'b1, 16'h0000, 16'h0000, 2'b00);
    #1;
    $display("txn: alt m0 read @0000");
    check_acks("alt0", 1'b1, 1'b0);
    push(1'b0, 16'h1111);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b1, 16'h0002, 16'h0000, 2'b00);
    #1;
    $display("txn: alt m1 read @0002");
    check_acks("alt1", 1'b0, 1'b1);
    check("alt1_mem_addr", bus.mem_addr, 16'h0002);
    push(1'b1, 16'h2222);
    @(negedge clk);
    drive(1, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(0, 1'b1, 16'h0004, 16'h0000, 2'b00);
    #1;
    $display("txn: alt m0 read @0004");
    check_acks("alt2", 1'b1, 1'b0);
    push(1'b0, 16'h3333);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 2'b00);

    // 6: reset in the cycle after an m1 read ack drops the return
    @(negedge clk);
    drive(1, 1'b1, 16'h0002, 16'h0000, 2'b00);
    #1;
    $display("txn: m1 read @0002 then reset");
    check_acks("rstrd", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    #1;
    check("rstrd_m1_rvalid_in_rst", bus.m1_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rstrd_m1_rvalid_after%0d", i), bus.m1_rvalid, 1'b0);
    end

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
